// File: rtl/quarter_wave_pkg.sv
//------------------------------------------------------------------------------
// Module   : quarter_wave_pkg
// Purpose  : Shared types and constants for the quarter-wave sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package quarter_wave_pkg;

  typedef enum logic [1:0] {
    Q_RISE     = 2'd0,
    Q_FALL     = 2'd1,
    Q_NEG_RISE = 2'd2,
    Q_NEG_FALL = 2'd3
  } quadrant_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIDSCALE = 512;
  localparam int IDX_MAX  = 127;

endpackage

`default_nettype wire

// File: rtl/quarter_wave_rate_divider.sv
//------------------------------------------------------------------------------
// Module   : rate_divider
// Purpose  : Programmable step pacer; ticks once every rate_div+1 running cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rate_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] rate_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_count;

  // >= so that lowering rate_div below the live count fires immediately
  assign tick = run && !clear && (r_count >= rate_div);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/quarter_wave_sequencer.sv
//------------------------------------------------------------------------------
// Module   : quarter_wave_sequencer
// Purpose  : Sweeps a quarter-wave ROM through four quadrants into a sample stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module quarter_wave_sequencer
  import quarter_wave_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(IDX_MAX + 1),
  parameter int DATA_WIDTH = $clog2(MIDSCALE) + 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  period_start,
  output logic [1:0]            quadrant
);

  localparam logic [ADDR_WIDTH-1:0] C_IDX_MAX  = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] C_MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                r_state;
  state_t                w_state_next;
  quadrant_t             r_quad;
  quadrant_t             w_quad_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_idx_next;
  logic                  w_run;
  logic                  w_step;
  logic                  r_s1_valid, r_s1_inv, r_s1_first;
  logic                  r_s2_valid, r_s2_inv, r_s2_first;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable)  w_state_next = RUN;
      RUN:     if (!enable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Gating by enable as well keeps a RUN->IDLE cycle from issuing a read
  assign w_run = (r_state == RUN) && enable;

  rate_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_divider (
    .clk      (clk),
    .reset    (reset),
    .run      (w_run),
    .clear    (restart),
    .rate_div (rate_div),
    .tick     (w_step)
  );

  // Endpoints repeat across quadrant boundaries: the index holds while the quadrant moves
  always_comb begin
    w_quad_next = r_quad;
    w_idx_next  = r_idx;
    case (r_quad)
      Q_RISE, Q_NEG_RISE: begin
        if (r_idx == C_IDX_MAX) w_quad_next = quadrant_t'(r_quad + 2'd1);
        else                    w_idx_next  = r_idx + 1'b1;
      end
      default: begin
        if (r_idx == '0) w_quad_next = quadrant_t'(r_quad + 2'd1);
        else             w_idx_next  = r_idx - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_quad <= Q_RISE;
      r_idx  <= '0;
    end else if (w_step) begin
      r_quad <= w_quad_next;
      r_idx  <= w_idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= '0;
      quadrant   <= 2'd0;
      r_s1_valid <= 1'b0;
      r_s1_inv   <= 1'b0;
      r_s1_first <= 1'b0;
    end else begin
      r_s1_valid <= w_step;
      if (w_step) begin
        mem_addr   <= r_idx;
        quadrant   <= r_quad;
        r_s1_inv   <= r_quad[1];
        r_s1_first <= (r_quad == Q_RISE) && (r_idx == '0);
      end
    end
  end

  // Stage 2 lines up with the ROM's registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_inv   <= 1'b0;
      r_s2_first <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_inv   <= r_s1_inv;
      r_s2_first <= r_s1_first;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample       <= C_MIDSCALE;
      sample_valid <= 1'b0;
      period_start <= 1'b0;
    end else begin
      sample_valid <= r_s2_valid;
      period_start <= r_s2_valid && r_s2_first;
      if (r_s2_valid) sample <= r_s2_inv ? ~mem_data : mem_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quarter_wave_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_quarter_wave_sequencer
// Purpose  : Directed scoreboard bench for quarter_wave_sequencer with an identity ROM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_quarter_wave_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, restart;
  logic [15:0] rate_div;
  logic [6:0]  mem_addr;
  logic [9:0]  mem_data;
  logic [9:0]  sample;
  logic        sample_valid, period_start;
  logic [1:0]  quadrant;

  always #5 clk = ~clk;

  quarter_wave_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .restart      (restart),
    .rate_div     (rate_div),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .period_start (period_start),
    .quadrant     (quadrant)
  );

  // Synchronous ROM holding entry i = i, words offset to 512+i
  always_ff @(posedge clk) mem_data <= 10'd512 + {3'b000, mem_addr};

  typedef struct {
    int         due;
    logic [9:0] val;
    logic       first;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   n_edges    = 0;

  int   m_state, m_cnt, m_q, m_idx, m_last_q, m_last_idx;
  bit   m_tick;
  int   got_val[$];
  bit   got_ps[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour for the edge about to happen, using the inputs now applied
  task automatic step_model();
    bit         run;
    logic [9:0] v;
    m_tick = 1'b0;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_q = 0; m_idx = 0;
      sb.delete();
    end else begin
      run    = (m_state == 1) && enable;
      m_tick = run && !restart && (m_cnt >= int'(rate_div));
      if (restart) begin
        m_cnt = 0; m_q = 0; m_idx = 0;
      end else if (run) begin
        m_cnt = m_tick ? 0 : m_cnt + 1;
      end
      if (m_tick) begin
        v = 10'(512 + m_idx);
        if (m_q >= 2) v = ~v;
        sb.push_back('{n_edges + 3, v, (m_q == 0 && m_idx == 0)});
        m_last_q   = m_q;
        m_last_idx = m_idx;
        if (m_q == 0 || m_q == 2) begin
          if (m_idx == 127) m_q = (m_q + 1) % 4;
          else              m_idx++;
        end else begin
          if (m_idx == 0) m_q = (m_q + 1) % 4;
          else            m_idx--;
        end
      end
      m_state = enable ? 1 : 0;
    end
  endtask

  task automatic tick();
    exp_t e;
    step_model();
    @(posedge clk);
    n_edges++;
    #1;
    if (m_tick) begin
      chk("issue_addr", mem_addr, m_last_idx);
      chk("issue_quadrant", quadrant, m_last_q);
    end
    if (sample_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", sample_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("sample_edge", n_edges, e.due);
        chk("sample", sample, e.val);
        chk("period_start", period_start, e.first);
      end
      got_val.push_back(int'(sample));
      got_ps.push_back(period_start);
    end else if (sb.size() > 0 && sb[0].due <= n_edges) begin
      chk("missing_valid", sample_valid, 1);
      e = sb.pop_front();
    end
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sample_valid) begin
        at = n_edges;
        break;
      end
    end
    if (at < 0) chk("valid_timeout", sample_valid, 1);
  endtask

  task automatic run_until(input int q, input int idx, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (m_tick && m_last_q == q && m_last_idx == idx) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  task automatic wait_step(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (m_tick) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  initial begin
    int a, b, c, cnt, ps_cnt;
    reset = 1'b1; enable = 1'b1; restart = 1'b0; rate_div = 16'd0;

    // Reset held with enable high
    tick();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_sample", sample, 512);
    chk("rst_valid", sample_valid, 0);
    chk("rst_quadrant", quadrant, 0);
    chk("rst_period_start", period_start, 0);
    repeat (4) begin
      tick();
      chk("rst_hold_valid", sample_valid, 0);
    end

    // Full-rate sweep across more than one period
    reset = 1'b0;
    got_val.delete(); got_ps.delete();
    repeat (520) tick();
    chk("sweep_count", got_val.size(), 517);
    if (got_val.size() >= 513) begin
      chk("sweep_s0",   got_val[0],   512);
      chk("sweep_s127", got_val[127], 639);
      chk("sweep_s128", got_val[128], 639);
      chk("sweep_s255", got_val[255], 512);
      chk("sweep_s256", got_val[256], 511);
      chk("sweep_s383", got_val[383], 384);
      chk("sweep_s384", got_val[384], 384);
      chk("sweep_s511", got_val[511], 511);
      chk("sweep_s512", got_val[512], 512);
      ps_cnt = 0;
      for (int i = 0; i < 512; i++) ps_cnt += int'(got_ps[i]);
      chk("sweep_ps_once", ps_cnt, 1);
      chk("sweep_ps_first", got_ps[0], 1);
      chk("sweep_ps_wrap", got_ps[512], 1);
    end

    // Divided rates
    rate_div = 16'd3;
    repeat (12) tick();
    wait_valid(a); wait_valid(b); wait_valid(c);
    chk("div3_gap_a", b - a, 4);
    chk("div3_gap_b", c - b, 4);
    rate_div = 16'd1;
    wait_valid(a); wait_valid(a); wait_valid(b); wait_valid(c);
    chk("div1_gap_a", b - a, 2);
    chk("div1_gap_b", c - b, 2);

    // Pause after Q1 idx 50, then resume
    rate_div = 16'd0;
    run_until(1, 50, "reach_q1_i50");
    enable = 1'b0;
    cnt = 0;
    repeat (22) begin
      tick();
      if (sample_valid) cnt++;
    end
    chk("pause_drain_count", cnt, 2);
    enable = 1'b1;
    wait_step("resume_step");
    chk("resume_addr", mem_addr, 49);
    chk("resume_quadrant", quadrant, 1);

    // Restart during Q2 idx 70
    run_until(2, 70, "reach_q2_i70");
    restart = 1'b1;
    tick();
    restart = 1'b0;
    wait_step("restart_step");
    chk("restart_addr", mem_addr, 0);
    chk("restart_quadrant", quadrant, 0);
    tick(); tick();
    chk("restart_valid", sample_valid, 1);
    chk("restart_ps", period_start, 1);
    chk("restart_sample", sample, 512);

    // Reset in the middle of Q3
    run_until(3, 100, "reach_q3_i100");
    reset = 1'b1;
    tick();
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_sample", sample, 512);
    chk("midrst_valid", sample_valid, 0);
    chk("midrst_quadrant", quadrant, 0);
    chk("midrst_period_start", period_start, 0);
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk("midrst_no_pending", sample_valid, 0);
    end
    repeat (6) tick();
    enable = 1'b0;
    repeat (5) tick();
    chk("final_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quarter_wave_sequencer.md
Name: quarter_wave_sequencer

Overview:
Drives the 128-entry quarter-wave sample ROM to produce a full 512-sample periodic waveform. Each quadrant is one 128-address sweep:
- Q0: addresses up, positive.
- Q1: addresses down, positive.
- Q2: addresses up, inverted.
- Q3: addresses down, inverted.

The block paces sample issue with a programmable rate divider and applies negative-half inversion to the ROM's 10-bit word. It produces a registered sample stream with a valid strobe for the downstream DAC/PWM stage.

Parameters:
ADDR_WIDTH, 7, ROM address width (2^ADDR_WIDTH entries per quadrant)
DATA_WIDTH, 10, ROM word and output sample width
DIV_WIDTH, 16, rate divider width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  run/pause; while low, no new ROM reads are issued
restart  input  1  one-cycle pulse; returns phase to Q0 index 0 and clears the divider
rate_div  input  DIV_WIDTH  issue one step every rate_div+1 cycles
mem_addr  output  ADDR_WIDTH  registered read address to the ROM
mem_data  input  DATA_WIDTH  ROM read data, valid one clk after mem_addr
sample  output  DATA_WIDTH  registered output sample
sample_valid  output  1  one-cycle strobe, sample is new
period_start  output  1  strobes together with sample_valid for the Q0 index-0 sample
quadrant  output  2  quadrant of the most recently issued address

Behaviour:
- Reset values, all taking effect on the same clk edge:
  - mem_addr=0, sample=10'd512 (midscale), sample_valid=0, period_start=0, quadrant=0.
  - Phase = Q0/idx0, divider count = 0, pipeline valid bits = 0.
  - Reset overrides every other input, and any in-flight samples are dropped.
- FSM has two states, IDLE and RUN.
  - IDLE->RUN when enable=1. RUN->IDLE when enable=0.
  - In IDLE, phase and divider hold (pause, not clear) and the pipeline drains normally.
- Divider, in RUN:
  - A step fires when count >= rate_div; the count then reloads to 0. Otherwise count increments.
  - Using >= means a rate_div decrease below the current count fires on the next cycle.
  - rate_div=0 gives one step per clock.
- Step, on the same edge:
  - mem_addr <= current index; quadrant <= current quadrant; stage-1 valid <= 1; stage-1 invert <= quadrant[1]; stage-1 first <= (Q0 and idx0).
  - Phase then advances:
    - Q0/Q2: index increments; at 127 it holds at 127 and the quadrant increments.
    - Q1/Q3: index decrements; at 0 it holds at 0 and the quadrant increments. Q3 wraps to Q0.
  - Endpoints are therefore repeated across quadrant boundaries (idx 127 twice at Q0->Q1, idx 0 twice at Q1->Q2 etc.). This is intentional.
- Pipeline:
  - Edge E: step issues mem_addr.
  - Edge E+1: ROM data becomes valid; stage-2 valid and flags are copied from stage 1.
  - Edge E+2: sample <= invert ? (2^DATA_WIDTH-1 - mem_data) : mem_data. sample_valid=1 and period_start=first for exactly one cycle.
  - Latency is 2 clocks from issue to sample. Throughput is up to one sample per clock.
- Inversion is computed as a bitwise NOT of mem_data, with no arithmetic overflow.
- restart:
  - Phase becomes Q0/idx0 and count becomes 0 on that edge. No step fires in the restart cycle.
  - Samples already in flight still emerge.
  - restart has priority over the step when both occur in the same cycle.
- enable deassert mid-quadrant: at most 2 in-flight samples emerge, then sample holds its last value and sample_valid stays 0.

Decomposition:
- Package quarter_wave_pkg:
  - quadrant_t enum: Q_RISE=0, Q_FALL=1, Q_NEG_RISE=2, Q_NEG_FALL=3.
  - state_t enum: IDLE, RUN.
  - Constants MIDSCALE=512 and IDX_MAX=127.
- Sub-module rate_divider: count, compare, reload, clear. Outputs a tick.
- Phase/FSM logic and the 2-stage pipeline stay in the top module.

Test Plan:
All directed tests use the real ROM loaded with entry i = i, so ROM data = 512+i.
- Reset: assert reset with enable=1 -> the next cycle shows mem_addr=0, sample=512, sample_valid=0, quadrant=0. Hold reset for 5 cycles -> no sample_valid.
- rate_div=0, enable=1, 520 cycles:
  - Samples run 512..639, 639..512, then inverted 511..384, then 384..511, repeating.
  - sample_valid is high every cycle from the 3rd cycle after the first step.
  - period_start appears exactly once per 512 samples, with value 512.
- rate_div=3: sample_valid pulses are exactly 4 cycles apart. Change rate_div to 1 mid-run -> spacing becomes 2 cycles within 2 steps.
- Drop enable after the step issuing Q1 idx 50:
  - Exactly the in-flight samples (up to 2) emerge, then sample_valid=0 for 20 cycles.
  - Re-enable -> the next issued address is 49 in Q1.
- restart during Q2 idx 70 -> the next step issues addr 0 in Q0, with period_start on its sample 2 cycles later.
- Reset mid-run in Q3 -> the next cycle shows reset values and no pending sample_valid.
